// File: rtl/line_buffer_window_if.sv
// ---------------------------------------------------------------------------
// line_buffer_window_if
//   Pixel-stream and 3x3 window bundle for line_buffer_window.
//
//   Signals (direction seen from the window generator, modport slave):
//     wEnClk       in   global enable; all state holds while low
//     wFrameStart  in   start-of-frame strobe
//     wPixelValid  in   input pixel strobe
//     wPixelIn     in   raster-order input pixel, DATA_W bits
//     wPixel00..22 out  3x3 window, row index first, 22 = newest pixel
//     wWinValid    out  one-cycle pulse, window is a full interior window
//     wFrameDone   out  one-cycle pulse, last pixel of the frame accepted
//     wWinX/wWinY  out  10-bit coordinate of the window centre
//
//   modport master : pixel source / window consumer (e.g. a testbench)
//   modport slave  : line_buffer_window
// ---------------------------------------------------------------------------
interface line_buffer_window_if #(
  parameter int DATA_W = 24
);
  logic              wEnClk;
  logic              wFrameStart;
  logic              wPixelValid;
  logic [DATA_W-1:0] wPixelIn;

  logic [DATA_W-1:0] wPixel00;
  logic [DATA_W-1:0] wPixel01;
  logic [DATA_W-1:0] wPixel02;
  logic [DATA_W-1:0] wPixel10;
  logic [DATA_W-1:0] wPixel11;
  logic [DATA_W-1:0] wPixel12;
  logic [DATA_W-1:0] wPixel20;
  logic [DATA_W-1:0] wPixel21;
  logic [DATA_W-1:0] wPixel22;
  logic              wWinValid;
  logic              wFrameDone;
  logic [9:0]        wWinX;
  logic [9:0]        wWinY;

  modport master (
    output wEnClk, wFrameStart, wPixelValid, wPixelIn,
    input  wPixel00, wPixel01, wPixel02,
    input  wPixel10, wPixel11, wPixel12,
    input  wPixel20, wPixel21, wPixel22,
    input  wWinValid, wFrameDone, wWinX, wWinY
  );

  modport slave (
    input  wEnClk, wFrameStart, wPixelValid, wPixelIn,
    output wPixel00, wPixel01, wPixel02,
    output wPixel10, wPixel11, wPixel12,
    output wPixel20, wPixel21, wPixel22,
    output wWinValid, wFrameDone, wWinX, wWinY
  );
endinterface

// File: rtl/line_buffer_window.sv
// ---------------------------------------------------------------------------
// line_buffer_window
//   Streaming 3x3 sliding-window generator. Two IMG_WIDTH-deep line buffers
//   hold the previous two lines; a 3x3 register window shifts left on every
//   accepted pixel. Only interior windows (centre not on the image border)
//   are flagged valid, one cycle after the accept that completes them.
//
//   Parameters:
//     IMG_WIDTH   pixels per line  (3..1024)
//     IMG_HEIGHT  lines per frame  (3..1024)
//     DATA_W      pixel width (packed RGB888 by default)
//
//   Ports:
//     iClk   clock
//     wRst   asynchronous active-high reset
//     bus    line_buffer_window_if.slave (pixel input, window output)
//
//   Build option:
//     LBW_WIN_COORD_EN  defined   -> wWinX/wWinY carry the window centre
//                       undefined -> wWinX/wWinY are constant 0
// ---------------------------------------------------------------------------
module line_buffer_window #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_W     = 24
) (
  input  logic                 iClk,
  input  logic                 wRst,
  line_buffer_window_if.slave  bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   col_reg;
  logic [CW-1:0]   col_next;
  logic [RW-1:0]   row_reg;
  logic [RW-1:0]   row_next;

  logic            start;
  logic            accept;
  logic [CW-1:0]   acc_col;
  logic [RW-1:0]   acc_row;
  logic            last_col;
  logic            last_row;
  logic            win_pos;
  logic            frame_last;

  logic            win_valid_reg;
  logic            frame_done_reg;

  // A frame start restarts the raster immediately, so a pixel arriving in
  // the same cycle is placed at (0,0) rather than at the stale position.
  assign start      = bus.wEnClk & bus.wFrameStart;
  assign accept     = bus.wEnClk & bus.wPixelValid &
                      (bus.wFrameStart | (state_reg == RUN));
  assign acc_col    = bus.wFrameStart ? '0 : col_reg;
  assign acc_row    = bus.wFrameStart ? '0 : row_reg;
  assign last_col   = (acc_col == CW'(IMG_WIDTH - 1));
  assign last_row   = (acc_row == RW'(IMG_HEIGHT - 1));
  assign win_pos    = accept && (acc_col >= CW'(2)) && (acc_row >= RW'(2));
  assign frame_last = accept && last_col && last_row;

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge iClk or posedge wRst) begin
    if (wRst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (start) begin
          state_next = RUN;
        end else if (frame_last) begin
          state_next = DONE;
        end
      end
      DONE: if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Raster position counters
  // -------------------------------------------------------------------------
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (start) begin
      col_next = '0;
      row_next = '0;
    end
    if (accept) begin
      if (last_col) begin
        col_next = '0;
        row_next = last_row ? '0 : acc_row + 1'b1;
      end else begin
        col_next = acc_col + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or posedge wRst) begin
    if (wRst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // -------------------------------------------------------------------------
  // Line buffers (block RAM, registered read, contents never reset)
  //
  // The read port is addressed with col_next, so the word for the next
  // accept is already sitting in rd*_reg when that accept arrives. The write
  // address (acc_col) and read address (col_next) always differ because the
  // line is at least 3 pixels wide. line2 is fed from line1's read data,
  // which turns the pair into a two-line delay.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] line1_mem [IMG_WIDTH];
  logic [DATA_W-1:0] line2_mem [IMG_WIDTH];
  logic [DATA_W-1:0] rd1_reg;
  logic [DATA_W-1:0] rd2_reg;

  always_ff @(posedge iClk) begin
    if (accept) begin
      line1_mem[acc_col] <= bus.wPixelIn;
      line2_mem[acc_col] <= rd1_reg;
    end
    rd1_reg <= line1_mem[col_next];
    rd2_reg <= line2_mem[col_next];
  end

  // -------------------------------------------------------------------------
  // 3x3 window: each row is a 3-tap shift register; the new right column is
  // {line row-2, line row-1, incoming pixel}. Row 0 is the oldest line.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] new_col [3];

  assign new_col[0] = rd2_reg;
  assign new_col[1] = rd1_reg;
  assign new_col[2] = bus.wPixelIn;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_W-1:0] tap [3];

      always_ff @(posedge iClk or posedge wRst) begin
        if (wRst) begin
          tap[0] <= '0;
          tap[1] <= '0;
          tap[2] <= '0;
        end else if (accept) begin
          tap[0] <= tap[1];
          tap[1] <= tap[2];
          tap[2] <= new_col[gi];
        end
      end
    end
  endgenerate

  assign bus.wPixel00 = g_row[0].tap[0];
  assign bus.wPixel01 = g_row[0].tap[1];
  assign bus.wPixel02 = g_row[0].tap[2];
  assign bus.wPixel10 = g_row[1].tap[0];
  assign bus.wPixel11 = g_row[1].tap[1];
  assign bus.wPixel12 = g_row[1].tap[2];
  assign bus.wPixel20 = g_row[2].tap[0];
  assign bus.wPixel21 = g_row[2].tap[1];
  assign bus.wPixel22 = g_row[2].tap[2];

  // -------------------------------------------------------------------------
  // Pulses: recomputed every cycle so they drop after one cycle whenever the
  // next cycle has no qualifying accept (including enable-low cycles).
  // -------------------------------------------------------------------------
  always_ff @(posedge iClk or posedge wRst) begin
    if (wRst) begin
      win_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      win_valid_reg  <= win_pos;
      frame_done_reg <= frame_last;
    end
  end

  assign bus.wWinValid  = win_valid_reg;
  assign bus.wFrameDone = frame_done_reg;

  // -------------------------------------------------------------------------
  // Window centre coordinate, updated only together with a valid window so
  // it holds its last value between windows.
  // -------------------------------------------------------------------------
`ifdef LBW_WIN_COORD_EN
  logic [9:0] win_x_reg;
  logic [9:0] win_y_reg;

  always_ff @(posedge iClk or posedge wRst) begin
    if (wRst) begin
      win_x_reg <= '0;
      win_y_reg <= '0;
    end else if (win_pos) begin
      win_x_reg <= 10'(acc_col) - 10'd1;
      win_y_reg <= 10'(acc_row) - 10'd1;
    end
  end

  assign bus.wWinX = win_x_reg;
  assign bus.wWinY = win_y_reg;
`else
  assign bus.wWinX = '0;
  assign bus.wWinY = '0;
`endif

endmodule

// File: tb/tb_line_buffer_window.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_window
//   Directed + randomized bench for line_buffer_window with a 4x3 image.
//   The reference keeps the accepted frame as a 2-D pixel array and derives
//   each expected window straight from the image coordinates.
// ---------------------------------------------------------------------------
module tb_line_buffer_window;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  line_buffer_window_if #(.DATA_W(DW)) bus ();

  line_buffer_window #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (DW)
  ) dut (
    .iClk(clk),
    .wRst(rst),
    .bus (bus)
  );

  // Reference state
  int          total = 0;
  int          bad   = 0;
  int          stepn = 0;
  bit          run   = 0;
  int          mc    = 0;
  int          mr    = 0;
  logic [23:0] img [H][W];
  logic [23:0] ew  [3][3];
  bit          known = 1;
  int          ex    = 0;
  int          ey    = 0;

  // Per-frame observation
  int          pulses;
  int          dones;
  bit          first_seen;
  logic [23:0] first00, first11, first22;
  logic [9:0]  firstx, firsty;
  int          want_xy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit vexp, input bit dexp);
    chk("win_valid", 32'(bus.wWinValid), 32'(vexp));
    chk("frame_done", 32'(bus.wFrameDone), 32'(dexp));
    if (known) begin
      chk("p00", 32'(bus.wPixel00), 32'(ew[0][0]));
      chk("p01", 32'(bus.wPixel01), 32'(ew[0][1]));
      chk("p02", 32'(bus.wPixel02), 32'(ew[0][2]));
      chk("p10", 32'(bus.wPixel10), 32'(ew[1][0]));
      chk("p11", 32'(bus.wPixel11), 32'(ew[1][1]));
      chk("p12", 32'(bus.wPixel12), 32'(ew[1][2]));
      chk("p20", 32'(bus.wPixel20), 32'(ew[2][0]));
      chk("p21", 32'(bus.wPixel21), 32'(ew[2][1]));
      chk("p22", 32'(bus.wPixel22), 32'(ew[2][2]));
    end
    chk("win_x", 32'(bus.wWinX), 32'(ex));
    chk("win_y", 32'(bus.wWinY), 32'(ey));
  endtask

  task automatic model_reset();
    run = 0; mc = 0; mr = 0; known = 1; ex = 0; ey = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        ew[i][j] = '0;
  endtask

  // One clock of stimulus, reference update, then checks #1 after the edge.
  task automatic step(input bit en, input bit fs, input bit pv, input logic [23:0] pix);
    bit acc;
    bit vexp;
    bit dexp;
    bus.wEnClk      = en;
    bus.wFrameStart = fs;
    bus.wPixelValid = pv;
    bus.wPixelIn    = pix;
    acc  = en && pv && (fs || run);
    vexp = 0;
    dexp = 0;
    if (en && fs) begin
      mc = 0; mr = 0; run = 1;
    end
    if (acc) begin
      img[mr][mc] = pix;
      if (mr >= 2 && mc >= 2) begin
        vexp  = 1;
        known = 1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            ew[i][j] = img[mr-2+i][mc-2+j];
`ifdef LBW_WIN_COORD_EN
        ex = mc - 1;
        ey = mr - 1;
`endif
      end else begin
        known = 0;
      end
      if (mc == W-1 && mr == H-1) begin
        dexp = 1;
        run  = 0;
      end
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    @(posedge clk);
    #1;
    stepn++;
    $display("step %0d en=%0b fs=%0b pv=%0b pix=%06h -> valid=%0b done=%0b x=%0d y=%0d p00=%06h p22=%06h",
             stepn, en, fs, pv, pix, bus.wWinValid, bus.wFrameDone,
             bus.wWinX, bus.wWinY, bus.wPixel00, bus.wPixel22);
    if (bus.wWinValid) begin
      pulses++;
      if (!first_seen) begin
        first_seen = 1;
        first00 = bus.wPixel00;
        first11 = bus.wPixel11;
        first22 = bus.wPixel22;
        firstx  = bus.wWinX;
        firsty  = bus.wWinY;
      end
    end
    if (bus.wFrameDone) dones++;
    check_outputs(vexp, dexp);
  endtask

  function automatic logic [23:0] rc(input int r, input int c);
    return {8'h00, 8'(r), 8'(c)};
  endfunction

  task automatic clear_obs();
    pulses = 0; dones = 0; first_seen = 0;
  endtask

  // Start strobe, then a full 00RRCC frame; gap inserts an idle pixel slot
  // after every accept.
  task automatic frame_rc(input bit gap);
    step(1, 1, 0, 24'(0));
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1, 0, 1, rc(r, c));
        if (gap) step(1, 0, 0, 24'($urandom));
      end
  endtask

  task automatic frame_summary(input string tag);
    chk({tag, "_pulses"}, 32'(pulses), 32'd2);
    chk({tag, "_dones"}, 32'(dones), 32'd1);
    chk({tag, "_first_p00"}, 32'(first00), 32'h000000);
    chk({tag, "_first_p11"}, 32'(first11), 32'h000101);
    chk({tag, "_first_p22"}, 32'(first22), 32'h000202);
    chk({tag, "_first_x"}, 32'(firstx), 32'(want_xy));
    chk({tag, "_first_y"}, 32'(firsty), 32'(want_xy));
    chk({tag, "_last_p22"}, 32'(bus.wPixel22), 32'h000203);
  endtask

  task automatic async_reset();
    bus.wEnClk      = 0;
    bus.wPixelValid = 0;
    bus.wFrameStart = 0;
    #2 rst = 1;
    #1;
    chk("rst_valid", 32'(bus.wWinValid), 32'd0);
    chk("rst_done", 32'(bus.wFrameDone), 32'd0);
    chk("rst_p00", 32'(bus.wPixel00), 32'd0);
    chk("rst_p11", 32'(bus.wPixel11), 32'd0);
    chk("rst_p22", 32'(bus.wPixel22), 32'd0);
    chk("rst_x", 32'(bus.wWinX), 32'd0);
    chk("rst_y", 32'(bus.wWinY), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  initial begin
`ifdef LBW_WIN_COORD_EN
    want_xy = 1;
`else
    want_xy = 0;
`endif
    bus.wEnClk = 0; bus.wFrameStart = 0; bus.wPixelValid = 0; bus.wPixelIn = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = '0;
    model_reset();

    // Power-on reset and reset-state check
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_outputs(0, 0);

    // Basic frame
    clear_obs();
    frame_rc(0);
    frame_summary("basic");

    // Pixel valid every other cycle
    clear_obs();
    frame_rc(1);
    frame_summary("gapped");

    // Enable low for 5 cycles mid-line (start strobes there must be ignored)
    clear_obs();
    step(1, 1, 0, 24'(0));
    for (int k = 0; k < 5; k++) step(1, 0, 1, rc(k / W, k % W));
    for (int k = 0; k < 5; k++) step(0, 1'($urandom), 1, 24'($urandom));
    for (int k = 5; k < W*H; k++) step(1, 0, 1, rc(k / W, k % W));
    frame_summary("hold");

    // Abort after 6 accepts, then a full frame
    step(1, 1, 0, 24'(0));
    for (int k = 0; k < 6; k++) step(1, 0, 1, 24'($urandom));
    clear_obs();
    frame_rc(0);
    frame_summary("abort");

    // Asynchronous reset after 9 accepts; pixels ignored until a start
    step(1, 1, 0, 24'(0));
    for (int k = 0; k < 9; k++) step(1, 0, 1, 24'($urandom));
    async_reset();
    for (int k = 0; k < 6; k++) step(1, 0, 1, 24'($urandom));
    clear_obs();
    frame_rc(0);
    frame_summary("after_rst");

    // Pixels in DONE are ignored; start coincident with the first pixel
    for (int k = 0; k < 4; k++) step(1, 0, 1, 24'($urandom));
    clear_obs();
    step(1, 1, 1, rc(0, 0));
    for (int k = 1; k < W*H; k++) step(1, 0, 1, rc(k / W, k % W));
    frame_summary("fs_with_pix");

    // Random traffic: random enable, valid, data and occasional restarts
    for (int k = 0; k < 400; k++) begin
      bit fs;
      fs = run ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 5) == 0);
      step(1'($urandom_range(0, 3) != 0), fs, 1'($urandom_range(0, 3) != 0),
           24'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_buffer_window.md
LINE_BUFFER_WINDOW -- requirements
Module: line_buffer_window

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, meaning pixels per line (legal range 3..1024).
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, meaning lines per frame (legal range 3..1024).
REQ-003 SHALL have parameter DATA_W, default 24, meaning pixel width as packed RGB888.
REQ-004 SHALL have port iClk, input, 1 bit: the single clock. The design has one clock, iClk.
REQ-005 SHALL have port wRst, input, 1 bit: reset. Reset is asynchronous and active-high.
REQ-006 SHALL have port wEnClk, input, 1 bit: global enable. While it is low, all state holds.
REQ-007 SHALL have port wFrameStart, input, 1 bit: start-of-frame strobe.
REQ-008 SHALL have port wPixelValid, input, 1 bit: input pixel strobe.
REQ-009 SHALL have port wPixelIn, input, DATA_W bits: raster-order input pixel.
REQ-010 SHALL have ports wPixel00..wPixel22, output, DATA_W bits each: 3x3 window; row index first, 22 is the newest pixel.
REQ-011 SHALL have port wWinValid, output, 1 bit: window valid, a one-cycle pulse.
REQ-012 SHALL have port wFrameDone, output, 1 bit: last pixel of the frame accepted, a one-cycle pulse.
REQ-013 SHALL have ports wWinX and wWinY, output, 10 bits each: coordinate of the window centre.

Function
REQ-014 SHALL accept a pixel only in a cycle where wEnClk=1 and wPixelValid=1; this cycle is called "accept".
REQ-015 SHALL maintain a column counter col (0..IMG_WIDTH-1) and a row counter row (0..IMG_HEIGHT-1), both advancing on accept.
- col wraps to 0 after IMG_WIDTH-1, and row then increments.
REQ-016 SHALL hold two line buffers, each IMG_WIDTH deep, storing lines row-1 and row-2; both are read and written at address col on accept.
REQ-017 SHALL shift a 3x3 register window left by one column on accept.
- The new right column is {line row-2, line row-1, wPixelIn} at col.
REQ-018 SHALL register the window outputs, with latency exactly 1 cycle after accept.
- wPixel22 = pixel(row,col); wPixel00 = pixel(row-2,col-2).
REQ-019 SHALL pulse wWinValid=1 in the cycle after an accept where col>=2 and row>=2, and hold it 0 otherwise.
- Border windows are never emitted.
- A frame therefore produces (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
REQ-020 SHALL drive wWinX=col-1 and wWinY=row-1 of the accepted pixel, aligned with wWinValid.
REQ-021 SHALL keep the window and wWinValid horizontally clean across line wrap: windows at col 0 and col 1 of a new line are not valid.
REQ-022 SHALL pulse wFrameDone, aligned with the last window, on the accept at (IMG_WIDTH-1, IMG_HEIGHT-1).
- After that accept, it SHALL enter DONE state and ignore further pixels until wFrameStart.
REQ-023 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE->RUN on wFrameStart.
- RUN->DONE on the last accept.
- DONE->RUN on wFrameStart.
- Pixels received in IDLE are ignored.
REQ-024 SHALL, on wFrameStart, clear col, row and wWinValid.
- If wPixelValid and wEnClk are also high in that cycle, that pixel SHALL be accepted as (0,0).
- wFrameStart in mid-frame RUN SHALL abort the current frame the same way, with no wFrameDone.
REQ-025 SHALL hold outputs unchanged, except for clearing the pulses, in cycles without an accept.
- wWinValid and wFrameDone SHALL never stay high for two consecutive cycles unless two consecutive accepts each produce one.

Reset
REQ-026 SHALL, on wRst=1 and asynchronously, set FSM=IDLE, col=0, row=0, all window registers and wPixel00..22 to 0, and wWinValid, wFrameDone, wWinX, wWinY to 0.
REQ-027 SHALL NOT reset the line-buffer memory contents.
- Stale data is unobservable because of REQ-019.
REQ-028 SHALL abort any frame when reset is asserted mid-frame; after release, it SHALL wait in IDLE for wFrameStart.

Configuration
REQ-029 SHALL, when macro LBW_WIN_COORD_EN is defined, implement the wWinX and wWinY counters and outputs per REQ-020.
REQ-030 SHALL, when LBW_WIN_COORD_EN is undefined, keep ports wWinX and wWinY present but tied to constant 0, with no coordinate logic synthesized.

Verification
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=3, and pixel value 24'h00RRCC, where RR is the row and CC is the column.
REQ-031 Reset, then wFrameStart plus 12 consecutive accepts.
- Required: exactly 2 wWinValid pulses.
- First pulse: wPixel00=0x000000, wPixel11=0x000101, wPixel22=0x000202, wWinX=1, wWinY=1.
- Second pulse: wPixel22=0x000203.
- wFrameDone is coincident with the second pulse.
REQ-032 Same frame with wPixelValid deasserted every other cycle.
- Required: identical window values, and each valid pulse arrives exactly 1 cycle after its accept.
REQ-033 wEnClk held low for 5 cycles mid-line.
- Required: counters and outputs are frozen, and no pulses occur during the hold.
REQ-034 wFrameStart asserted after 6 accepts, then a full frame.
- Required: no wFrameDone for the aborted frame, and the new frame matches REQ-031.
REQ-035 wRst asserted for 1 cycle after 9 accepts.
- Required: all outputs are 0 immediately (asynchronously).
- Pixels are then ignored until wFrameStart.
REQ-036 Build without LBW_WIN_COORD_EN and run REQ-031.
- Required: wWinX=wWinY=0 throughout, with windows unchanged.
